sr_latch_nand: RTL and testbench



---
 rtl/sr_latch_nand_pkg.sv | 35 +++
 rtl/sr_latch_nand_if.sv | 28 ++
 rtl/sr_latch_nand_cell.sv | 66 ++++++
 rtl/sr_latch_nand.sv | 40 ++++
 tb/tb_sr_latch_nand.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sr_latch_nand_pkg.sv
`default_nettype none
//==============================================================================
// Module      : sr_latch_pkg
// Description : Shared encodings and next-state function for the registered
//               NAND SR latch. The input pair is packed as {S, R}, with S in
//               bit 1 and R in bit 0. Both inputs are active-low.
// Revision    : 1.0 - initial release
//==============================================================================
package sr_latch_pkg;

    localparam logic [1:0] SR_ILL  = 2'b00;  // both asserted: illegal, Q=P=1
    localparam logic [1:0] SR_SET  = 2'b01;  // S asserted
    localparam logic [1:0] SR_RST  = 2'b10;  // R asserted
    localparam logic [1:0] SR_HOLD = 2'b11;  // neither asserted

    // Returns the next {q, p} of one latch bit.
    // A hold from the illegal state (q=p=1) resolves to the reset state, so the
    // cell never keeps an ambiguous value. Real cross-coupled gates would race
    // at this point.
    function automatic logic [1:0] sr_next(input logic s, input logic r,
                                           input logic q, input logic p);
        logic [1:0] nxt;
        nxt = {q, p};
        case ({s, r})
            SR_ILL:  nxt = 2'b11;
            SR_SET:  nxt = 2'b10;
            SR_RST:  nxt = 2'b01;
            SR_HOLD: nxt = (q && p) ? 2'b01 : {q, p};
            default: nxt = {q, p};
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_nand_if.sv
`default_nettype none
//==============================================================================
// Module      : sr_latch_nand_if
// Description : Bus bundle for sr_latch_nand.
//               S, R : active-low set/reset per bit (master -> slave)
//               Q, P : registered output and its complement (slave -> master)
//               ILL  : sticky illegal-input flag. This signal exists only when
//                      SR_LATCH_ILLEGAL_FLAG_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
interface sr_latch_nand_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] P;
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
    logic [WIDTH-1:0] ILL;

    modport master (output S, output R, input Q, input P, input ILL);
    modport slave  (input S, input R, output Q, output P, output ILL);
`else
    modport master (output S, output R, input Q, input P);
    modport slave  (input S, input R, output Q, output P);
`endif
endinterface
`default_nettype wire

// File: rtl/sr_latch_nand_cell.sv
`default_nettype none
//==============================================================================
// Module      : sr_latch_cell
// Description : One-bit registered NAND SR latch.
//               Ports: clk, rst (sync, active-high), s_i/r_i (active-low),
//                      q_o/p_o (registered), ill_o (sticky illegal flag, which
//                      exists only when SR_LATCH_ILLEGAL_FLAG_EN is defined).
// Revision    : 1.0 - initial release
//==============================================================================
module sr_latch_cell
    import sr_latch_pkg::*;
#(
    parameter logic RST_Q = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic s_i,
    input  wire logic r_i,
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
    output logic      ill_o,
`endif
    output logic      q_o,
    output logic      p_o
);

    logic q_q, p_q, q_d, p_d;

    always_comb begin
        {q_d, p_d} = sr_next(s_i, r_i, q_q, p_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_Q;
            p_q <= ~RST_Q;
        end else begin
            q_q <= q_d;
            p_q <= p_d;
        end
    end

    assign q_o = q_q;
    assign p_o = p_q;

`ifdef SR_LATCH_ILLEGAL_FLAG_EN
    logic ill_q, ill_d;

    // The flag is sticky. Only reset clears it, and reset wins over an illegal
    // input sampled at the same edge.
    always_comb begin
        ill_d = ill_q | ({s_i, r_i} == SR_ILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign ill_o = ill_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sr_latch_nand.sv
`default_nettype none
//==============================================================================
// Module      : sr_latch_nand
// Description : WIDTH independent registered NAND SR latches.
//               Ports: CLK, RST (sync, active-high), bus (sr_latch_nand_if
//                      slave: S, R in; Q, P, and optional ILL out).
//               Optional feature: SR_LATCH_ILLEGAL_FLAG_EN adds the sticky
//                      per-bit ILL flag.
//               The WIDTH of the connected interface must match WIDTH here.
// Revision    : 1.0 - initial release
//==============================================================================
module sr_latch_nand
    import sr_latch_pkg::*;
#(
    parameter int   WIDTH = 1,
    parameter logic RST_Q = 1'b0
) (
    input wire logic     CLK,
    input wire logic     RST,
    sr_latch_nand_if.slave bus
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_latch_cell #(
            .RST_Q (RST_Q)
        ) u_cell (
            .clk   (CLK),
            .rst   (RST),
            .s_i   (bus.S[i]),
            .r_i   (bus.R[i]),
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
            .ill_o (bus.ILL[i]),
`endif
            .q_o   (bus.Q[i]),
            .p_o   (bus.P[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_nand.sv
`default_nettype none
//==============================================================================
// Module      : tb_sr_latch_nand
// Description : Self-checking bench for sr_latch_nand with WIDTH=4 and
//               RST_Q=0. It runs directed scenarios, then random stimulus. A
//               per-bit behavioural model is compared against the DUT on
//               every falling edge after the first reset.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sr_latch_nand;

    localparam int   W    = 4;
    localparam logic RSTQ = 1'b0;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    sr_latch_nand_if #(.WIDTH(W)) bus ();

    sr_latch_nand #(
        .WIDTH (W),
        .RST_Q (RSTQ)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int tests  = 0;
    int failed = 0;

    // Behavioural model: each bit tracks the state it is in.
    // The state codes are 0 for reset (Q=0), 1 for set (Q=1), 2 for illegal (Q=P=1).
    int  mstate [W];
    bit  mill   [W];
    bit  mvalid = 1'b0;

    always @(posedge CLK) begin
        for (int i = 0; i < W; i++) begin
            if (RST) begin
                mstate[i] = (RSTQ == 1'b1) ? 1 : 0;
                mill[i]   = 1'b0;
            end else if (!bus.S[i] && !bus.R[i]) begin
                mstate[i] = 2;
                mill[i]   = 1'b1;
            end else if (!bus.S[i]) begin
                mstate[i] = 1;
            end else if (!bus.R[i]) begin
                mstate[i] = 0;
            end else if (mstate[i] == 2) begin
                mstate[i] = 0;
            end
        end
        if (RST) mvalid = 1'b1;
    end

    function automatic logic [W-1:0] exp_q();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = (mstate[i] != 0);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_p();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = (mstate[i] != 1);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_ill();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = mill[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model is anchored by a reset.
    always @(negedge CLK) begin
        if (mvalid) begin
            chk("model_Q", bus.Q, exp_q());
            chk("model_P", bus.P, exp_p());
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
            chk("model_ILL", bus.ILL, exp_ill());
`endif
        end
    end

    // This task is called at a falling edge. It applies the inputs and returns
    // at the next falling edge, when the outputs reflect them.
    task automatic step(input logic rst, input logic [W-1:0] s, input logic [W-1:0] r);
        RST   = rst;
        bus.S = s;
        bus.R = r;
        @(negedge CLK);
    endtask

    initial begin
        RST   = 1'b0;
        bus.S = '1;
        bus.R = '1;
        @(negedge CLK);

        // Reset, then hold.
        step(1'b1, 4'b1111, 4'b1111);
        chk("rst_Q", bus.Q, 4'b0000);
        chk("rst_P", bus.P, 4'b1111);
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
        chk("rst_ILL", bus.ILL, 4'b0000);
`endif
        for (int k = 0; k < 3; k++) step(1'b0, 4'b1111, 4'b1111);
        chk("hold_after_rst_Q", bus.Q, 4'b0000);
        chk("hold_after_rst_P", bus.P, 4'b1111);

        // Illegal input, then resolve on hold.
        step(1'b0, 4'b0000, 4'b0000);
        chk("illegal_Q", bus.Q, 4'b1111);
        chk("illegal_P", bus.P, 4'b1111);
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
        chk("illegal_ILL", bus.ILL, 4'b1111);
`endif
        step(1'b0, 4'b1111, 4'b1111);
        chk("resolve_Q", bus.Q, 4'b0000);
        chk("resolve_P", bus.P, 4'b1111);
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
        chk("sticky_ILL", bus.ILL, 4'b1111);
`endif

        // Reset input, then set input, then a long hold.
        step(1'b0, 4'b1111, 4'b0000);
        chk("reset_in_Q", bus.Q, 4'b0000);
        chk("reset_in_P", bus.P, 4'b1111);
        step(1'b0, 4'b0000, 4'b1111);
        chk("set_Q", bus.Q, 4'b1111);
        chk("set_P", bus.P, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b1111, 4'b1111);
            chk("set_hold_Q", bus.Q, 4'b1111);
            chk("set_hold_P", bus.P, 4'b0000);
        end

        // Independent bits.
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b0, 4'b1110, 4'b1101);
        chk("mixed_Q", bus.Q, 4'b0001);
        chk("mixed_P", bus.P, 4'b1110);

        // Reset has priority over set and over the illegal input.
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);
        chk("rst_vs_set_Q", bus.Q, 4'b0000);
        chk("rst_vs_set_P", bus.P, 4'b1111);
        step(1'b1, 4'b0000, 4'b0000);
        chk("rst_vs_ill_Q", bus.Q, 4'b0000);
        chk("rst_vs_ill_P", bus.P, 4'b1111);
`ifdef SR_LATCH_ILLEGAL_FLAG_EN
        chk("rst_vs_ill_ILL", bus.ILL, 4'b0000);
`endif

        // Random stimulus, checked by the compare process. Holds are weighted
        // up so that the states persist and the illegal state resolves often.
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] s, r;
            s = W'($urandom) | W'($urandom);
            r = W'($urandom) | W'($urandom);
            step(($urandom_range(0, 24) == 0), s, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
